// File: rtl/wb_bus_arbiter.sv
// Two-master, one-slave Wishbone B4 arbiter: per-cycle grant held across bursts,
// round-robin on contention, and a watchdog that ends stalled transfers with err.
module wb_bus_arbiter #(
   parameter int DW  = 32,
   parameter int AW  = 32,
   parameter int TOW = 8
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [1:0]        i_m_cyc,
   input  logic [1:0]        i_m_stb,
   input  logic [1:0]        i_m_we,
   input  logic [2*AW-1:0]   i_m_addr,
   input  logic [2*DW-1:0]   i_m_data,
   input  logic [2*DW/8-1:0] i_m_sel,
   input  logic [5:0]        i_m_cti,
   output logic [1:0]        o_m_ack,
   output logic [1:0]        o_m_err,
   output logic [DW-1:0]     o_m_data,
   output logic [1:0]        o_m_gnt,
   output logic              o_wb_cyc,
   output logic              o_wb_stb,
   output logic              o_wb_we,
   output logic [AW-1:0]     o_wb_addr,
   output logic [DW-1:0]     o_wb_data,
   output logic [DW/8-1:0]   o_wb_sel,
   output logic [2:0]        o_wb_cti,
   input  logic              i_wb_ack,
   input  logic              i_wb_err,
   input  logic [DW-1:0]     i_wb_data
);

   typedef enum logic [1:0] {ST_IDLE, ST_GNT0, ST_GNT1} state_t;

   state_t          state_q, state_d;
   logic [1:0]      gnt_q, gnt_d;
   logic            last_q, last_d;
   logic [TOW-1:0]  tcnt_q, tcnt_d;
   logic            granted;
   logic            sel_m;
   logic            timeout;

   // Slave-side mux: everything is forced to zero while no master owns the bus.
   always_comb begin
      granted   = (state_q != ST_IDLE);
      sel_m     = (state_q == ST_GNT1);
      o_wb_cyc  = 1'b0;
      o_wb_stb  = 1'b0;
      o_wb_we   = 1'b0;
      o_wb_addr = '0;
      o_wb_data = '0;
      o_wb_sel  = '0;
      o_wb_cti  = '0;
      if (granted) begin
         o_wb_cyc  = i_m_cyc[sel_m];
         o_wb_stb  = i_m_stb[sel_m];
         o_wb_we   = i_m_we[sel_m];
         o_wb_addr = sel_m ? i_m_addr[AW +: AW]     : i_m_addr[0 +: AW];
         o_wb_data = sel_m ? i_m_data[DW +: DW]     : i_m_data[0 +: DW];
         o_wb_sel  = sel_m ? i_m_sel[DW/8 +: DW/8]  : i_m_sel[0 +: DW/8];
         o_wb_cti  = sel_m ? i_m_cti[3 +: 3]        : i_m_cti[0 +: 3];
      end
   end

   // Watchdog fires on the stb cycle that finds the counter already saturated.
   assign timeout  = o_wb_stb && (tcnt_q == {TOW{1'b1}});
   assign o_m_ack  = gnt_q & {2{i_wb_ack}};
   assign o_m_err  = gnt_q & {2{i_wb_err | timeout}};
   assign o_m_gnt  = gnt_q;
   assign o_m_data = i_wb_data;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      tcnt_d  = '0;
      case (state_q)
         ST_IDLE: begin
            if (i_m_cyc[0] && (!i_m_cyc[1] || last_q)) state_d = ST_GNT0;
            else if (i_m_cyc[1])                         state_d = ST_GNT1;
         end
         ST_GNT0, ST_GNT1: begin
            if (!i_m_cyc[sel_m]) begin
               state_d = ST_IDLE;
               last_d  = sel_m;
            end else if (o_wb_stb && !i_wb_ack && !i_wb_err && !timeout) begin
               tcnt_d = tcnt_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      gnt_d = {state_d == ST_GNT1, state_d == ST_GNT0};
   end

   // NOTE: state is updated with non-blocking assignments so all flops sample pre-edge values.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
         gnt_q   <= 2'b00;
         last_q  <= 1'b1;
         tcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         last_q  <= last_d;
         tcnt_q  <= tcnt_d;
      end
   end

endmodule
